// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-lane parking occupancy counter.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_A  = 3'd1,
    ENT_AB = 3'd2,
    ENT_B  = 3'd3,
    EXT_B  = 3'd4,
    EXT_AB = 3'd5,
    EXT_A  = 3'd6
  } lane_state_t;

  // Sensor pair codes are {a, b}.
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One gate lane: 2-FF sensor synchroniser, direction FSM and registered event pulses.
module parking_lane_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic enter_evt,
  output logic exit_evt
);

  logic [1:0]  ab_p0, ab_p1;
  lane_state_t state, state_nxt;
  logic        ent_fire, ext_fire;
  logic        ent_vld_p2, ext_vld_p2;

  // Stage p0/p1: synchroniser; p2: FSM + fire flag; output: event pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_p0      <= AB_NONE;
      ab_p1      <= AB_NONE;
      state      <= IDLE;
      ent_vld_p2 <= 1'b0;
      ext_vld_p2 <= 1'b0;
      enter_evt  <= 1'b0;
      exit_evt   <= 1'b0;
    end else begin
      ab_p0      <= {sensor_a, sensor_b};
      ab_p1      <= ab_p0;
      state      <= state_nxt;
      ent_vld_p2 <= ent_fire;
      ext_vld_p2 <= ext_fire;
      enter_evt  <= ent_vld_p2;
      exit_evt   <= ext_vld_p2;
    end
  end

  always_comb begin
    state_nxt = state;
    ent_fire  = 1'b0;
    ext_fire  = 1'b0;
    case (state)
      IDLE: begin
        case (ab_p1)
          AB_A:    state_nxt = ENT_A;
          AB_B:    state_nxt = EXT_B;
          default: state_nxt = IDLE;
        endcase
      end
      ENT_A: begin
        case (ab_p1)
          AB_BOTH: state_nxt = ENT_AB;
          AB_A:    state_nxt = ENT_A;
          default: state_nxt = IDLE;
        endcase
      end
      ENT_AB: begin
        case (ab_p1)
          AB_BOTH: state_nxt = ENT_AB;
          AB_A:    state_nxt = ENT_A;
          AB_B:    state_nxt = ENT_B;
          default: state_nxt = IDLE;
        endcase
      end
      ENT_B: begin
        case (ab_p1)
          AB_B:    state_nxt = ENT_B;
          AB_BOTH: state_nxt = ENT_AB;
          AB_NONE: begin
            state_nxt = IDLE;
            ent_fire  = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
      EXT_B: begin
        case (ab_p1)
          AB_BOTH: state_nxt = EXT_AB;
          AB_B:    state_nxt = EXT_B;
          default: state_nxt = IDLE;
        endcase
      end
      EXT_AB: begin
        case (ab_p1)
          AB_BOTH: state_nxt = EXT_AB;
          AB_B:    state_nxt = EXT_B;
          AB_A:    state_nxt = EXT_A;
          default: state_nxt = IDLE;
        endcase
      end
      EXT_A: begin
        case (ab_p1)
          AB_A:    state_nxt = EXT_A;
          AB_BOTH: state_nxt = EXT_AB;
          AB_NONE: begin
            state_nxt = IDLE;
            ext_fire  = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/parking_occupancy_multilane.sv
// Merges per-lane enter/exit pulses into one saturating occupancy counter with load and flags.
module parking_occupancy_multilane
  import parking_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] sensor_a,
  input  logic [N_LANES-1:0] sensor_b,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  input  logic               clr_err,
  output logic [N_LANES-1:0] enter_evt,
  output logic [N_LANES-1:0] exit_evt,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               sat_err
);

  localparam int                      SUM_W  = CNT_W + 4;
  localparam logic [CNT_W-1:0]        CAP_U  = CNT_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] CAP_S  = SUM_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] ZERO_S = '0;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    parking_lane_fsm u_lane (
      .clk       (clk),
      .rst       (rst),
      .sensor_a  (sensor_a[i]),
      .sensor_b  (sensor_b[i]),
      .enter_evt (enter_evt[i]),
      .exit_evt  (exit_evt[i])
    );
  end

  // Returns {clamped, value}.
  function automatic logic [CNT_W:0] clamp_sum(input logic signed [SUM_W-1:0] s);
    if (s > CAP_S)       return {1'b1, CAP_U};
    else if (s < ZERO_S) return {1'b1, {CNT_W{1'b0}}};
    else                 return {1'b0, s[CNT_W-1:0]};
  endfunction

  function automatic logic [CNT_W:0] clamp_load(input logic [CNT_W-1:0] v);
    if (v > CAP_U) return {1'b1, CAP_U};
    else           return {1'b0, v};
  endfunction

  logic [3:0]              n_in, n_out;
  logic signed [SUM_W-1:0] sum_p0;
  logic [CNT_W:0]          upd_res, ld_res;
  logic                    sat_set;

  // Only the net sum is clamped, so opposing events on different lanes cancel first.
  always_comb begin
    n_in    = popcount(8'(enter_evt));
    n_out   = popcount(8'(exit_evt));
    sum_p0  = $signed({4'b0000, count}) + $signed(SUM_W'(n_in)) - $signed(SUM_W'(n_out));
    upd_res = clamp_sum(sum_p0);
    ld_res  = clamp_load(load_val);
    sat_set = load ? ld_res[CNT_W] : upd_res[CNT_W];
  end

  // Stage p1: occupancy register; load overrides this cycle's events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      sat_err <= 1'b0;
    end else begin
      count   <= load ? ld_res[CNT_W-1:0] : upd_res[CNT_W-1:0];
      sat_err <= sat_set | (sat_err & ~clr_err);
    end
  end

  assign full  = (count == CAP_U);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_occupancy_multilane.sv
// Self-checking bench: table-driven lane sequences plus hand-written corner cases, event scoreboard.
module tb_parking_occupancy_multilane;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sensor_a, sensor_b;
  logic       load;
  logic [7:0] load_val;
  logic       clr_err;
  logic [1:0] enter_evt, exit_evt;
  logic [7:0] count;
  logic       full, empty, sat_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    logic [1:0] ent;
    logic [1:0] ext;
  } evt_t;
  evt_t exp_q[$];

  typedef struct {
    int         lane;
    logic [7:0] seq;
    logic       ent;
    logic       ext;
    int         pre;
    int         exp_cnt;
    logic       exp_sat;
  } row_t;
  row_t rows[8];

  parking_occupancy_multilane #(.N_LANES(2), .CNT_W(8), .CAPACITY(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_a  (sensor_a),
    .sensor_b  (sensor_b),
    .load      (load),
    .load_val  (load_val),
    .clr_err   (clr_err),
    .enter_evt (enter_evt),
    .exit_evt  (exit_evt),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .sat_err   (sat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Samples outputs at the falling edge, then advances to just after the next rising edge.
  task automatic tick();
    evt_t e;
    @(negedge clk);
    if (!rst && (enter_evt != 2'b00 || exit_evt != 2'b00)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", int'({enter_evt, exit_evt}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_mask", int'({enter_evt, exit_evt}), int'({e.ent, e.ext}));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [1:0] ab0, input logic [1:0] ab1);
    sensor_a = {ab1[1], ab0[1]};
    sensor_b = {ab1[0], ab0[0]};
  endtask

  // Final 00 is driven after edge cyc; pulse lands on edge cyc+4.
  task automatic expect_evt(input logic [1:0] ent, input logic [1:0] ext);
    evt_t e;
    e.cyc = cyc + 4;
    e.ent = ent;
    e.ext = ext;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = 8'(v);
    tick();
    load     = 1'b0;
  endtask

  task automatic drain_check();
    chk("missing_evt", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [1:0] ab;
    logic [1:0] lm;

    rows[0] = '{0, 8'b10_11_01_00, 1'b1, 1'b0, 0,   1,   1'b0};
    rows[1] = '{1, 8'b01_11_10_00, 1'b0, 1'b1, 5,   4,   1'b0};
    rows[2] = '{0, 8'b10_11_10_00, 1'b0, 1'b0, 3,   3,   1'b0};
    rows[3] = '{1, 8'b11_00_00_00, 1'b0, 1'b0, 3,   3,   1'b0};
    rows[4] = '{0, 8'b01_11_10_00, 1'b0, 1'b1, 0,   0,   1'b1};
    rows[5] = '{1, 8'b10_11_01_00, 1'b1, 1'b0, 200, 200, 1'b1};
    rows[6] = '{1, 8'b10_11_01_00, 1'b1, 1'b0, 199, 200, 1'b0};
    rows[7] = '{0, 8'b10_01_00_00, 1'b0, 1'b0, 9,   9,   1'b0};

    rst = 1'b1; load = 1'b0; load_val = '0; clr_err = 1'b0;
    drive(2'b00, 2'b00);
    ticks(3);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_sat", int'(sat_err), 0);
    chk("rst_evt", int'({enter_evt, exit_evt}), 0);
    rst = 1'b0;
    ticks(2);

    for (int r = 0; r < 8; r++) begin
      do_load(rows[r].pre);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      lm = (rows[r].lane == 0) ? 2'b01 : 2'b10;
      for (int j = 0; j < 4; j++) begin
        ab = rows[r].seq[7-2*j -: 2];
        if (rows[r].lane == 0) drive(ab, 2'b00);
        else                   drive(2'b00, ab);
        if (j == 3 && (rows[r].ent || rows[r].ext))
          expect_evt(rows[r].ent ? lm : 2'b00, rows[r].ext ? lm : 2'b00);
        ticks(4);
      end
      ticks(8);
      chk($sformatf("row%0d_count", r), int'(count), rows[r].exp_cnt);
      chk($sformatf("row%0d_sat", r), int'(sat_err), int'(rows[r].exp_sat));
      chk($sformatf("row%0d_full", r), int'(full), (rows[r].exp_cnt == 200) ? 1 : 0);
      chk($sformatf("row%0d_empty", r), int'(empty), (rows[r].exp_cnt == 0) ? 1 : 0);
      drain_check();
    end

    // Lane0 entry and lane1 exit completing together net out.
    do_load(7);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    drive(2'b10, 2'b01); ticks(4);
    drive(2'b11, 2'b11); ticks(4);
    drive(2'b01, 2'b10); ticks(4);
    drive(2'b00, 2'b00);
    expect_evt(2'b01, 2'b10);
    ticks(12);
    chk("net_count", int'(count), 7);
    chk("net_sat", int'(sat_err), 0);
    drain_check();

    // Two simultaneous entries from 199 clamp at capacity.
    do_load(199);
    drive(2'b10, 2'b10); ticks(4);
    drive(2'b11, 2'b11); ticks(4);
    drive(2'b01, 2'b01); ticks(4);
    drive(2'b00, 2'b00);
    expect_evt(2'b11, 2'b00);
    ticks(12);
    chk("sat2_count", int'(count), 200);
    chk("sat2_full", int'(full), 1);
    chk("sat2_sat", int'(sat_err), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_sat", int'(sat_err), 0);
    drain_check();

    // Load coinciding with an event pulse discards the event from the count.
    do_load(20);
    drive(2'b10, 2'b00); ticks(4);
    drive(2'b11, 2'b00); ticks(4);
    drive(2'b01, 2'b00); ticks(4);
    drive(2'b00, 2'b00);
    expect_evt(2'b01, 2'b00);
    ticks(4);
    load = 1'b1; load_val = 8'd10;
    tick();
    load = 1'b0;
    ticks(4);
    chk("ldpulse_count", int'(count), 10);
    drain_check();

    // Oversized load clamps and flags.
    do_load(250);
    chk("ldbig_count", int'(count), 200);
    chk("ldbig_sat", int'(sat_err), 1);

    // Async reset in the middle of an entry; the rest of the car produces nothing.
    drive(2'b10, 2'b00); ticks(4);
    drive(2'b11, 2'b00); ticks(4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_sat", int'(sat_err), 0);
    chk("mid_rst_evt", int'({enter_evt, exit_evt}), 0);
    tick();
    rst = 1'b0;
    drive(2'b01, 2'b00); ticks(4);
    drive(2'b00, 2'b00); ticks(10);
    chk("post_rst_count", int'(count), 0);
    drain_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_multilane.md
Name: parking_occupancy_multilane

Overview:
- Multi-lane successor to the single-entrance parking counter.
- Tracks N_LANES independent A/B sensor pairs, each decoded by its own direction FSM.
- Net enter/exit events from all lanes are merged into one saturating occupancy counter with full/empty flags, a sticky saturation error and a manual load.
- Sits between the raw gate sensors and the display/barrier controller.

Parameters:
- N_LANES, 2, number of gate lanes (1..8).
- CNT_W, 8, occupancy counter width.
- CAPACITY, 200, maximum occupancy; must be ≤ 2^CNT_W-1 and ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- sensor_a  in  N_LANES  per-lane outer sensor, asynchronous to clk.
- sensor_b  in  N_LANES  per-lane inner sensor, asynchronous to clk.
- load  in  1  synchronous overwrite of occupancy.
- load_val  in  CNT_W  value for load; clamped to CAPACITY.
- clr_err  in  1  clears sat_err.
- enter_evt  out  N_LANES  one-cycle pulse per completed entry, per lane.
- exit_evt  out  N_LANES  one-cycle pulse per completed exit, per lane.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- sat_err  out  1  sticky: an update was clamped.

Behaviour:
- Reset (async, rst=1):
  - All synchronisers cleared to 0.
  - All lane FSMs go to IDLE.
  - enter_evt=0, exit_evt=0, count=0, empty=1, full=0, sat_err=0.
- Synchroniser: each sensor bit passes through a 2-FF synchroniser; the lane FSM sees only the synchronised AB.
- Lane FSM states (registered Moore): IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A.
  - IDLE: 10→ENT_A; 01→EXT_B; 00 or 11 stays IDLE (11 from IDLE is ignored).
  - ENT_A: 11→ENT_AB; 10 stay; 00→IDLE (abort); 01→IDLE (illegal).
  - ENT_AB: 11 stay; 10→ENT_A; 01→ENT_B; 00→IDLE (illegal).
  - ENT_B: 01 stay; 11→ENT_AB; 00→IDLE and register enter_evt=1 for the next cycle; 10→IDLE.
  - Exit path mirrors the entry path with A and B swapped; EXT_A on 00→IDLE registers exit_evt.
- Event pulses:
  - Exactly one cycle wide, registered.
  - An event pulse asserts on the 3rd rising edge after the edge that first samples the final raw 00.
  - Aborts and illegal transitions produce no pulse and no error.
- Occupancy update, on the edge following the pulse cycle:
  - n_in = popcount(enter_evt), n_out = popcount(exit_evt).
  - Sum computed in CNT_W+4 bits signed: s = count + n_in − n_out.
  - If s > CAPACITY: count=CAPACITY, sat_err←1.
  - If s < 0: count=0, sat_err←1.
  - Otherwise count=s.
  - Simultaneous entries and exits on different lanes net out; clamping applies to the net value only.
- load:
  - Highest priority. count←min(load_val, CAPACITY); event pulses in that cycle are discarded from the count but still appear on enter_evt/exit_evt.
  - load_val > CAPACITY also sets sat_err.
- clr_err: clears sat_err on the next edge unless a new saturation occurs in that same cycle (set wins).
- full/empty: combinational decodes of the count register, so no extra latency.
- Reset mid-sequence: a lane partially through a sequence returns to IDLE; the remainder of that car's sequence produces no event.

Decomposition:
- Package parking_pkg holds:
  - the lane_state_t enum (7 states, 3-bit encoding),
  - the AB code constants (AB_NONE=00, AB_A=10, AB_B=01, AB_BOTH=11),
  - a popcount function.
- Sub-module parking_lane_fsm holds the 2-FF synchroniser, the lane FSM and the registered enter/exit pulses. It is instantiated N_LANES times via generate.
- The top level holds the merge adder, clamping, load logic and flags.

Test Plan:
- Lane0 AB 00→10→11→01→00, each held 4 cycles:
  - enter_evt[0] pulses exactly once, 3 edges after 00 is applied;
  - count 0→1; empty falls the cycle count becomes 1.
- Lane1 exit sequence 00→01→11→10→00 with count=5 → exit_evt[1] single pulse; count=4.
- Lane0 entry and lane1 exit completing the same cycle, count=7 → both pulses in one cycle; count stays 7; sat_err=0.
- Entry aborted (00→10→11→10→00), then illegal 00→11→00 → no pulses; count unchanged.
- load=1, load_val=199; then two lanes complete entries the same cycle (CAPACITY=200):
  - count=200, full=1, sat_err=1;
  - clr_err → sat_err=0 next cycle.
- count=0, single exit → count stays 0, sat_err=1. Assert rst mid-entry (state ENT_AB) → all outputs at reset values; finishing the sequence afterwards yields no enter_evt.
